// File: rtl/tpu_cmd_pkg.sv
// Shared definitions for the GEMM command path (dispatcher, control unit, benches).
// Contents:
//   command_t     packed 64-bit GEMM descriptor, MSB->LSB
//                 addr_d, addr_c, addr_b, addr_a, len_n, len_k, len_m
//   ERR_*         bit constants for the dispatcher err_code output
//   disp_state_e  one-hot dispatcher FSM states
package tpu_cmd_pkg;

    localparam int CMD_ADDR_W = 10;
    localparam int CMD_LEN_W  = 8;
    localparam int CMD_W      = 4 * CMD_ADDR_W + 3 * CMD_LEN_W;

    typedef struct packed {
        logic [CMD_ADDR_W-1:0] addr_d;
        logic [CMD_ADDR_W-1:0] addr_c;
        logic [CMD_ADDR_W-1:0] addr_b;
        logic [CMD_ADDR_W-1:0] addr_a;
        logic [CMD_LEN_W-1:0]  len_n;
        logic [CMD_LEN_W-1:0]  len_k;
        logic [CMD_LEN_W-1:0]  len_m;
    } command_t;

    localparam logic [2:0] ERR_LEN  = 3'b001;
    localparam logic [2:0] ERR_WRAP = 3'b010;
    localparam logic [2:0] ERR_RSVD = 3'b100;

    typedef enum logic [2:0] {
        IDLE      = 3'b001,
        ISSUE     = 3'b010,
        WAIT_DONE = 3'b100
    } disp_state_e;

endpackage

// File: rtl/cmd_sync_fifo.sv
// Parameterised synchronous FIFO with flush.
// Ports:
//   clk, rst      clock, synchronous active-low reset (pointers/count only)
//   flush         empties the FIFO on the next edge; a push in the same cycle is dropped
//   push, wr_data write side (ignored when full)
//   pop, rd_data  read side; rd_data shows the head entry (first-word fall-through)
//   count         registered occupancy
//   full, empty   from the registered pointers (extra MSB separates full from empty)
module cmd_sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign rd_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    // Storage carries no reset; validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/cmd_dispatcher.sv
// GEMM command queue and dispatcher in front of control_unit.
// Validates host descriptors, queues legal ones, and issues one command at a
// time, waiting for done_irq before issuing the next.
// Ports:
//   clk, rst                 clock, synchronous active-low reset
//   host_cmd_valid/_data     host descriptor in; host_cmd_ready = queue not full
//   flush                    drop all queued (not yet issued) descriptors
//   cmd_valid/_data/_ready   issue handshake to control_unit
//   done_irq                 completion pulse from control_unit
//   err_valid, err_code      one-cycle reject pulse, code held until next reject
//   queue_count              occupied queue entries
//   done_count               completed commands (wraps)
//   idle                     queue empty and FSM in IDLE
module cmd_dispatcher
    import tpu_cmd_pkg::*;
#(
    parameter int ADDR_WIDTH           = 10,
    parameter int SYSTOLIC_ARRAY_WIDTH = 16,
    parameter int DEPTH                = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      host_cmd_valid,
    input  logic [63:0]               host_cmd_data,
    output logic                      host_cmd_ready,
    input  logic                      flush,
    output logic                      cmd_valid,
    output logic [63:0]               cmd_data,
    input  logic                      cmd_ready,
    input  logic                      done_irq,
    output logic                      err_valid,
    output logic [2:0]                err_code,
    output logic [$clog2(DEPTH):0]    queue_count,
    output logic [15:0]               done_count,
    output logic                      idle
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    command_t          host_cmd;
    logic [63:0]       head_data;
    logic              fifo_full;
    logic              fifo_empty;
    logic              xfer;
    logic              push;
    logic              pop;
    logic              rej;
    logic [2:0]        chk_code;
    logic [CNT_W-1:0]  count_nxt;
    disp_state_e       state;
    disp_state_e       state_nxt;

    function automatic logic len_bad(input logic [CMD_LEN_W-1:0] len);
        return (len == '0) || (int'(len) > SYSTOLIC_ARRAY_WIDTH);
    endfunction

    // addr_d + len_m - 1 must stay inside the buffer; compared as addr_d + len_m
    // so a zero len_m cannot underflow.
    function automatic logic wrap_bad(input logic [CMD_ADDR_W-1:0] addr,
                                      input logic [CMD_LEN_W-1:0]  len);
        return (int'(addr) + int'(len)) > (1 << ADDR_WIDTH);
    endfunction

    assign host_cmd = command_t'(host_cmd_data);
    assign host_cmd_ready = !fifo_full;

    always_comb begin
        chk_code = '0;
        if (len_bad(host_cmd.len_m) || len_bad(host_cmd.len_k) || len_bad(host_cmd.len_n))
            chk_code = chk_code | ERR_LEN;
        if (wrap_bad(host_cmd.addr_d, host_cmd.len_m))
            chk_code = chk_code | ERR_WRAP;
    end

    // A transfer in a flush cycle is consumed silently.
    assign xfer = host_cmd_valid && host_cmd_ready && !flush;
    assign push = xfer && (chk_code == '0);
    assign rej  = xfer && (chk_code != '0);

    cmd_sync_fifo #(
        .WIDTH (64),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush   (flush),
        .push    (push),
        .wr_data (host_cmd),
        .pop     (pop),
        .rd_data (head_data),
        .count   (queue_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                // Popping during a flush would issue an entry the host just discarded.
                if (!fifo_empty && !flush) begin
                    pop       = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (cmd_ready) state_nxt = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (done_irq) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign count_nxt = flush ? '0
                     : queue_count + CNT_W'(push) - CNT_W'(pop);

    always_ff @(posedge clk) begin
        if (!rst) begin
            cmd_valid  <= 1'b0;
            cmd_data   <= '0;
            err_valid  <= 1'b0;
            err_code   <= '0;
            done_count <= '0;
            idle       <= 1'b1;
        end else begin
            if (pop) begin
                cmd_valid <= 1'b1;
                cmd_data  <= head_data;
            end else if (state == ISSUE && cmd_ready) begin
                cmd_valid <= 1'b0;
            end
            err_valid <= rej;
            if (rej) err_code <= chk_code;
            if (state == WAIT_DONE && done_irq) done_count <= done_count + 16'd1;
            idle <= (state_nxt == IDLE) && (count_nxt == '0);
        end
    end

endmodule

// File: tb/tb_cmd_dispatcher.sv
// Self-checking bench for cmd_dispatcher: directed scenarios followed by random
// traffic, every cycle compared against a queue-based behavioural model.
module tb_cmd_dispatcher;

    localparam int DEPTH = 4;
    localparam int SAW   = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        host_cmd_valid;
    logic [63:0] host_cmd_data;
    logic        host_cmd_ready;
    logic        flush;
    logic        cmd_valid;
    logic [63:0] cmd_data;
    logic        cmd_ready;
    logic        done_irq;
    logic        err_valid;
    logic [2:0]  err_code;
    logic [2:0]  queue_count;
    logic [15:0] done_count;
    logic        idle;

    cmd_dispatcher #(
        .ADDR_WIDTH           (10),
        .SYSTOLIC_ARRAY_WIDTH (SAW),
        .DEPTH                (DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .host_cmd_valid (host_cmd_valid),
        .host_cmd_data  (host_cmd_data),
        .host_cmd_ready (host_cmd_ready),
        .flush          (flush),
        .cmd_valid      (cmd_valid),
        .cmd_data       (cmd_data),
        .cmd_ready      (cmd_ready),
        .done_irq       (done_irq),
        .err_valid      (err_valid),
        .err_code       (err_code),
        .queue_count    (queue_count),
        .done_count     (done_count),
        .idle           (idle)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        else
            n_pass++;
    endtask

    // Reference model: pending commands, the command held at the output, and
    // whether the dispatcher is idle / offering / awaiting completion.
    logic [63:0] mq[$];
    int          m_phase;   // 0 free, 1 offering to control_unit, 2 awaiting done
    logic        m_valid;
    logic [63:0] m_data;
    logic [15:0] m_done;
    logic        m_errv;
    logic [2:0]  m_errc;

    function automatic logic [63:0] mk(int d, int c, int b, int a, int n, int k, int m);
        logic [63:0] v;
        v = {10'(d), 10'(c), 10'(b), 10'(a), 8'(n), 8'(k), 8'(m)};
        return v;
    endfunction

    function automatic logic [2:0] rule_code(logic [63:0] v);
        int m, k, n, ad;
        logic [2:0] c;
        m  = int'(v[7:0]);
        k  = int'(v[15:8]);
        n  = int'(v[23:16]);
        ad = int'(v[63:54]);
        c  = 3'b000;
        if (m < 1 || m > SAW || k < 1 || k > SAW || n < 1 || n > SAW) c[0] = 1'b1;
        if (ad + m - 1 >= 1024) c[1] = 1'b1;
        return c;
    endfunction

    task automatic model_edge();
        bit         accept;
        logic [2:0] c;
        if (!rst) begin
            mq.delete();
            m_phase = 0; m_valid = 0; m_data = '0; m_done = '0; m_errv = 0; m_errc = '0;
            return;
        end
        accept = host_cmd_valid && (mq.size() < DEPTH);
        if (m_phase == 0) begin
            if (mq.size() > 0 && !flush) begin
                m_data  = mq.pop_front();
                m_valid = 1;
                m_phase = 1;
            end
        end else if (m_phase == 1) begin
            if (cmd_ready) begin
                m_valid = 0;
                m_phase = 2;
            end
        end else if (done_irq) begin
            m_done  = m_done + 16'd1;
            m_phase = 0;
        end
        m_errv = 0;
        if (flush) begin
            mq.delete();
        end else if (accept) begin
            c = rule_code(host_cmd_data);
            if (c == 3'b000) mq.push_back(host_cmd_data);
            else begin
                m_errv = 1;
                m_errc = c;
            end
        end
    endtask

    task automatic compare_all();
        check("cmd_valid",      cmd_valid,      m_valid);
        check("cmd_data",       cmd_data,       m_data);
        check("host_cmd_ready", host_cmd_ready, (mq.size() < DEPTH));
        check("queue_count",    queue_count,    mq.size());
        check("done_count",     done_count,     m_done);
        check("idle",           idle,           (mq.size() == 0 && m_phase == 0));
        check("err_valid",      err_valid,      m_errv);
        check("err_code",       err_code,       m_errc);
    endtask

    task automatic step(input bit r, input bit hv, input logic [63:0] hd,
                        input bit fl, input bit cr, input bit di);
        rst            = r;
        host_cmd_valid = hv;
        host_cmd_data  = hd;
        flush          = fl;
        cmd_ready      = cr;
        done_irq       = di;
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic nop(input int n, input bit cr);
        for (int i = 0; i < n; i++) step(1, 0, 64'h0, 0, cr, 0);
    endtask

    logic [63:0] d1, dx;

    initial begin
        rst = 0; host_cmd_valid = 0; host_cmd_data = '0; flush = 0; cmd_ready = 0; done_irq = 0;
        m_phase = 0; m_valid = 0; m_data = '0; m_done = '0; m_errv = 0; m_errc = '0;

        // Reset values
        step(0, 0, 64'h0, 0, 0, 0);
        step(0, 0, 64'h0, 0, 0, 0);

        // Single legal descriptor, output held stable while cmd_ready is low
        d1 = mk(12'h200, 12'h100, 12'h100, 12'h100, 8, 8, 16);
        step(1, 1, d1, 0, 0, 0);
        nop(1, 0);
        check("first_issue_valid", cmd_valid, 1'b1);
        check("first_issue_data",  cmd_data,  d1);
        nop(5, 0);
        check("held_data", cmd_data, d1);
        step(1, 0, 64'h0, 0, 1, 0);
        step(1, 0, 64'h0, 0, 0, 1);
        nop(1, 0);

        // Five pushes with cmd_ready low: one at the output, four fill the queue
        for (int i = 0; i < 5; i++) step(1, 1, mk(i * 16, 1, 2, 3, i + 1, 2, 3), 0, 0, 0);
        check("full_not_ready", host_cmd_ready, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(1, 0, 64'h0, 0, 1, 0);
            step(1, 0, 64'h0, 0, 0, 1);
            nop(1, 0);
        end

        // Rejected descriptors: bad len_k, then addr_d window wrap
        step(1, 1, mk(5, 0, 0, 0, 4, 0, 4), 0, 0, 0);
        nop(1, 0);
        step(1, 1, mk(12'h3F8, 0, 0, 0, 4, 4, 16), 0, 0, 0);
        check("wrap_code_stage", err_valid, 1'b1);
        nop(2, 0);

        // Flush while waiting for completion
        for (int i = 0; i < 4; i++) step(1, 1, mk(i, i, i, i, 2, 3, 4), 0, 0, 0);
        step(1, 0, 64'h0, 0, 1, 0);
        step(1, 1, mk(9, 9, 9, 9, 1, 1, 1), 1, 0, 0);
        nop(1, 0);
        step(1, 0, 64'h0, 0, 0, 1);
        nop(2, 0);

        // Reset while offering, then a stray done_irq
        for (int i = 0; i < 3; i++) step(1, 1, mk(i + 7, 0, 0, 0, 5, 5, 5), 0, 0, 0);
        step(0, 0, 64'h0, 0, 0, 0);
        nop(1, 0);
        step(1, 0, 64'h0, 0, 0, 1);

        // Simultaneous push and pop at queue_count = 2; done_irq in IDLE
        step(1, 1, mk(1, 1, 1, 1, 1, 1, 1), 0, 0, 0);
        nop(1, 0);
        step(1, 0, 64'h0, 0, 1, 0);
        step(1, 1, mk(2, 2, 2, 2, 2, 2, 2), 0, 0, 0);
        step(1, 1, mk(3, 3, 3, 3, 3, 3, 3), 0, 0, 0);
        step(1, 0, 64'h0, 0, 0, 1);
        step(1, 1, mk(4, 4, 4, 4, 4, 4, 4), 0, 0, 0);
        check("push_pop_count", queue_count, 3'd2);
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 64'h0, 0, 1, 0);
            step(1, 0, 64'h0, 0, 0, 1);
            nop(1, 0);
        end
        step(1, 0, 64'h0, 0, 0, 1);

        // Random traffic
        for (int i = 0; i < 2000; i++) begin
            int m, k, n, ad;
            m  = ($urandom_range(0, 9) < 8) ? int'($urandom_range(1, 16)) : int'($urandom_range(0, 30));
            k  = ($urandom_range(0, 9) < 8) ? int'($urandom_range(1, 16)) : int'($urandom_range(0, 30));
            n  = ($urandom_range(0, 9) < 8) ? int'($urandom_range(1, 16)) : int'($urandom_range(0, 30));
            ad = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1000, 1023)) : int'($urandom_range(0, 1023));
            dx = mk(ad, $urandom_range(0, 1023), $urandom_range(0, 1023), $urandom_range(0, 1023), n, k, m);
            step(($urandom_range(0, 299) != 0), ($urandom_range(0, 1) == 1), dx,
                 ($urandom_range(0, 39) == 0), ($urandom_range(0, 1) == 1),
                 ($urandom_range(0, 9) < 3));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
